// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: word/mask types, arbiter FSM
// state encoding and grant identifiers.
package lc3b_mem_arbiter_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum bit [1:0] {arb_idle, arb_serve_i, arb_serve_d} lc3b_arb_state;
   typedef enum bit {grant_i, grant_d} lc3b_arb_grant;

   // Width of the starvation counter; STARVE_LIMIT must fit in it.
   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_arbiter_sat_counter.sv
// lc3b_sat_counter: saturating up-counter with synchronous clear and
// increment controls. Clear has priority; holds when neither is asserted.
module lc3b_sat_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   // Clear wins over increment; increment stops at MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_V)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares the single LC-3b memory port between instruction
// fetch (I) and data access (D). One requester is granted at a time; its
// command is latched and the memory response is routed back to it.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined: D has priority on ties, with a starvation counter that forces
//              I ahead after STARVE_LIMIT consecutive D grants over a pending I.
//   defined:   ties go to the opposite of the last grant; counter tied to 0.
//
// Handshake: a requester raises x_read/x_write and holds it (with stable
// address/data) until x_resp pulses for one cycle. The arbiter samples
// requests only in IDLE; during SERVE the latched command alone drives memory,
// so requester changes are ignored until the response. mem_resp is a 1-cycle
// pulse from memory; x_resp is combinational from it in the same cycle.
// There is always one IDLE cycle between transactions.
//
// dbg_state / dbg_starve_cnt / dbg_last_grant expose internal state for checkers.
module lc3b_mem_arbiter
   import lc3b_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_read,
   input  lc3b_word                  i_address,
   output lc3b_word                  i_rdata,
   output logic                      i_resp,
   input  logic                      d_read,
   input  logic                      d_write,
   input  lc3b_mem_wmask             d_wmask,
   input  lc3b_word                  d_address,
   input  lc3b_word                  d_wdata,
   output lc3b_word                  d_rdata,
   output logic                      d_resp,
   output logic                      mem_read,
   output logic                      mem_write,
   output lc3b_mem_wmask             mem_wmask,
   output lc3b_word                  mem_address,
   output lc3b_word                  mem_wdata,
   input  lc3b_word                  mem_rdata,
   input  logic                      mem_resp,
   output lc3b_arb_state             dbg_state,
   output logic [STARVE_CNT_W-1:0]   dbg_starve_cnt,
   output lc3b_arb_grant             dbg_last_grant
);

   lc3b_arb_state             state;
   lc3b_arb_grant             last_grant;
   logic                      mem_read_q;
   logic                      mem_write_q;
   lc3b_word                  cmd_addr;
   lc3b_word                  cmd_wdata;
   lc3b_mem_wmask             cmd_wmask;
   lc3b_word                  i_rdata_q;
   lc3b_word                  d_rdata_q;
   logic [STARVE_CNT_W-1:0]   starve_cnt;

   logic i_req;
   logic d_req;
   logic d_wins;
   logic start;

   assign i_req = i_read;
   assign d_req = d_read | d_write;
   assign start = (state == arb_idle) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
   // Round-robin mode does not track starvation.
   assign starve_cnt = '0;

   // Winner selection: sole requester wins; ties alternate against last_grant.
   always_comb begin
      d_wins = 1'b0;
      if (d_req && !i_req) begin
         d_wins = 1'b1;
      end else if (d_req && i_req) begin
         d_wins = (last_grant == grant_i);
      end
   end
`else
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT_V = STARVE_CNT_W'(STARVE_LIMIT);

   logic cnt_inc;
   logic cnt_clr;

   // Count D grants that overtake a waiting fetch; any I grant resets it.
   assign cnt_inc = start && d_wins && i_req;
   assign cnt_clr = start && !d_wins;

   lc3b_sat_counter #(
      .WIDTH (STARVE_CNT_W),
      .MAX   (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .count (starve_cnt)
   );

   // Winner selection: sole requester wins; ties go to D until I has starved.
   always_comb begin
      d_wins = 1'b0;
      if (d_req && !i_req) begin
         d_wins = 1'b1;
      end else if (d_req && i_req) begin
         d_wins = (starve_cnt != STARVE_LIMIT_V);
      end
   end
`endif

   // Arbiter FSM: grants in IDLE, latches the command, waits for mem_resp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= arb_idle;
         last_grant  <= grant_i;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         cmd_wmask   <= '0;
      end else begin
         case (state)
            arb_idle: begin
               if (start) begin
                  if (d_wins) begin
                     state      <= arb_serve_d;
                     last_grant <= grant_d;
                     cmd_addr   <= d_address;
                     // A simultaneous read+write is treated as a write.
                     if (d_write) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b1;
                        cmd_wdata   <= d_wdata;
                        cmd_wmask   <= d_wmask;
                     end else begin
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        cmd_wdata   <= '0;
                        cmd_wmask   <= '0;
                     end
                  end else begin
                     state       <= arb_serve_i;
                     last_grant  <= grant_i;
                     cmd_addr    <= i_address;
                     mem_read_q  <= 1'b1;
                     mem_write_q <= 1'b0;
                     cmd_wdata   <= '0;
                     cmd_wmask   <= '0;
                  end
               end
            end
            arb_serve_i, arb_serve_d: begin
               if (mem_resp) begin
                  state       <= arb_idle;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
               end
            end
            default: begin
               state       <= arb_idle;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign i_resp = (state == arb_serve_i) && mem_resp;
   assign d_resp = (state == arb_serve_d) && mem_resp;

   // Keep the last read data of each requester between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (i_resp) begin
            i_rdata_q <= mem_rdata;
         end
         if (d_resp) begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
   assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_wmask   = cmd_wmask;
   assign mem_address = cmd_addr;
   assign mem_wdata   = cmd_wdata;

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;
   assign dbg_last_grant = last_grant;

   // The data port must never request a read and a write together.
   a_no_d_rw: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule
